calc2_port_responder: RTL and testbench
=======================================

# calc2_port_responder

Single-port responder for the calc2 request/response protocol: it accepts the two-cycle command/operand requests that the calc2 bench drivers issue and returns one tagged response per accepted command. It queues up to four outstanding commands in arrival order, executes them on one add/sub/shift unit with configurable latency, and flags protocol violations. It is the RTL end of the interface the bench drives, and serves as the golden single-port model for calc2 bring-up.

## Interface
- ADD_LAT, 2: cycles from pop to response for add/sub (≥1).
- SHIFT_LAT, 3: cycles from pop to response for shifts (≥1).
- c_clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_cmd_in  in  4  opcode; 0 means no request.
- req_tag_in  in  2  tag, sampled in the command cycle.
- req_data_in  in  32 [0:31]  operand1 in the command cycle, operand2 in the next cycle.
- out_resp  out  2  00 none, 01 success, 10 error; 11 is never driven.
- out_data  out  32 [0:31]  result; bit 31 is the LSB.
- out_tag  out  2  tag of the response.
- proto_err  out  1  sticky protocol-violation flag; cleared only by reset.

## Operation
- Capture FSM states are CAP_IDLE and CAP_OP2.
  - CAP_IDLE with a nonzero cmd: latch cmd, tag and operand1, then go to CAP_OP2.
  - CAP_OP2: latch operand2, enqueue the entry, return to CAP_IDLE. req_cmd_in is ignored in this state.
- Acceptance check, made in the command cycle:
  - A tag is busy if it is enqueued or executing and its response is not on out in this cycle.
  - Busy tag, or FIFO holding 4 entries: the request is dropped (its operand2 cycle is still consumed) and proto_err sets.
- Tag busy vector: a bit sets at enqueue and clears in the cycle its response is driven.
- Exec FSM states are EX_IDLE and EX_BUSY.
  - EX_IDLE with a non-empty FIFO: pop the head, load the counter with LAT-1, go to EX_BUSY.
  - EX_BUSY: decrement the counter. At 0, register the response and return to EX_IDLE; a new pop may happen in that same cycle.
- Arithmetic, on 32-bit unsigned operands:
  - add: result = op1+op2. A carry-out gives out_resp=10 and out_data=0.
  - sub: result = op1−op2. If op2>op1, out_resp=10 and out_data=0.
  - shift_left / shift_right: logical shift of op1 by op2[27:31]; never an error.
  - Opcodes other than 1, 2, 5, 6 are accepted and queued, then answered with resp 10, data 0, LAT=1.
- Responses are strictly in arrival order.

## Timing
- Reset (async): out_resp=00, out_data=0, out_tag=0, proto_err=0. FIFO, busy vector and both FSMs are cleared; in-flight and half-captured requests are discarded.
- Timing is counted from a request whose command cycle is N:
  - Enqueue happens on the edge ending N+1.
  - The earliest pop P is N+2; there is no bypass.
  - The response is on out in cycle P+LAT, for exactly 1 cycle. out_resp=00 in every other cycle, and out_data/out_tag hold their last values.
- Throughput is one response per LAT cycles.
- Simultaneous events:
  - Enqueue and pop in the same cycle are both honoured.
  - A tag whose response is on out in cycle N may be reused by a command in cycle N.
- A nonzero cmd in the CAP_OP2 cycle is treated as operand2 data only; it never sets proto_err.

## Structure
- The shared package calc2_pkg holds:
  - the existing operation_t;
  - a new resp_t enum: resp_none=2'b00, resp_ok=2'b01, resp_err=2'b10;
  - the constant CALC2_QDEPTH=4.
- Sub-module calc2_tag_fifo: a 4-entry FIFO of {operation_t, tag, op1, op2} with push/pop/full/empty/count, supporting simultaneous push and pop.
- The capture FSM, exec FSM, busy vector and ALU live in calc2_port_responder.

## Test plan
- Add path: add 0x0000_0005 + 0x0000_0007, tag 2, default params → out_resp=01, data 0x0000_000C, tag 2, at cycle N+4.
- Error results:
  - add 0xFFFF_FFFF + 1 → resp 10, data 0.
  - sub 3 − 5 → resp 10, data 0.
  - sub 5 − 3 → resp 01, data 2.
- Shifts:
  - shl 0x0000_0001 by 0x0000_0021 → data 0x0000_0002 (only the low 5 bits are used).
  - shr 0x8000_0000 by 31 → data 1.
- Ordering and throughput: tags 0-3 issued back-to-back, as add, shl, sub, add → responses in order 0, 1, 2, 3; no gap other than the LAT spacing; FIFO never overflows.
- Protocol errors:
  - Reusing tag 1 while it is outstanding → request dropped, proto_err=1, exactly one response for tag 1.
  - Opcode 4'b0011 → resp 10, data 0.
- Reset mid-operation: assert reset with 3 commands queued → all outputs 0 immediately, no stale responses after release, and a fresh add works with normal latency.

Source files
------------

// File: rtl/calc2_pkg.sv
// Shared types for the calc2 request/response protocol: opcodes, response codes,
// queue entry layout and the reference arithmetic used by the responder.
package calc2_pkg;

   typedef enum logic [3:0] {
      op_none = 4'd0,
      op_add  = 4'd1,
      op_sub  = 4'd2,
      op_shl  = 4'd5,
      op_shr  = 4'd6
   } operation_t;

   typedef enum logic [1:0] {
      resp_none = 2'b00,
      resp_ok   = 2'b01,
      resp_err  = 2'b10
   } resp_t;

   localparam int unsigned CALC2_QDEPTH = 4;

   typedef enum logic {CAP_IDLE, CAP_OP2} cap_state_t;
   typedef enum logic {EX_IDLE, EX_BUSY} ex_state_t;

   typedef struct packed {
      operation_t  op;
      logic [1:0]  tag;
      logic [31:0] op1;
      logic [31:0] op2;
   } entry_t;

   typedef struct packed {
      resp_t       resp;
      logic [31:0] data;
   } result_t;

   // Unsigned overflow/underflow reports an error with zeroed data.
   function automatic result_t calc2_alu(input entry_t e);
      result_t     r;
      logic [32:0] sum;
      r.resp = resp_ok;
      r.data = '0;
      sum    = '0;
      case (e.op)
         op_add: begin
            sum = {1'b0, e.op1} + {1'b0, e.op2};
            if (sum[32]) r.resp = resp_err;
            else         r.data = sum[31:0];
         end
         op_sub: begin
            if (e.op2 > e.op1) r.resp = resp_err;
            else               r.data = e.op1 - e.op2;
         end
         op_shl:  r.data = e.op1 << e.op2[4:0];
         op_shr:  r.data = e.op1 >> e.op2[4:0];
         default: r.resp = resp_err;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/calc2_tag_fifo.sv
// Small in-order FIFO of queued calc2 commands; push and pop may occur together.
module calc2_tag_fifo
   import calc2_pkg::*;
#(
   parameter int unsigned DEPTH = CALC2_QDEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  entry_t                   push_entry,
   input  logic                     pop,
   output entry_t                   head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   entry_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_entry;
   end

endmodule

// File: rtl/calc2_port_responder.sv
// Single-port calc2 responder: two-cycle request capture, 4-deep in-order queue,
// one add/sub/shift unit with per-operation latency, sticky protocol-error flag.
module calc2_port_responder
   import calc2_pkg::*;
#(
   parameter int unsigned ADD_LAT   = 2,
   parameter int unsigned SHIFT_LAT = 3
) (
   input  logic        c_clk,
   input  logic        reset,
   input  logic [3:0]  req_cmd_in,
   input  logic [1:0]  req_tag_in,
   input  logic [0:31] req_data_in,
   output logic [1:0]  out_resp,
   output logic [0:31] out_data,
   output logic [1:0]  out_tag,
   output logic        proto_err
);

   localparam int unsigned CW = $clog2(CALC2_QDEPTH) + 1;

   cap_state_t  cap_state, cap_next;
   operation_t  cap_op;
   logic [1:0]  cap_tag;
   logic [31:0] cap_op1;
   logic        cap_keep;
   logic        cmd_seen;
   logic        accept;

   ex_state_t   ex_state, ex_next;
   logic [7:0]  cnt, cnt_next;
   entry_t      cur;
   entry_t      head;
   entry_t      push_entry;
   entry_t      fire_src;
   result_t     res;
   logic        push, pop, fire;
   logic        full, empty;
   logic [CW-1:0] count;
   logic [3:0]  busy, busy_next;

   function automatic logic [7:0] lat_of(input operation_t op);
      case (op)
         op_add, op_sub: lat_of = 8'(ADD_LAT);
         op_shl, op_shr: lat_of = 8'(SHIFT_LAT);
         default:        lat_of = 8'd1;
      endcase
   endfunction

   calc2_tag_fifo #(.DEPTH(CALC2_QDEPTH)) u_fifo (
      .clk        (c_clk),
      .rst        (reset),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .head       (head),
      .full       (full),
      .empty      (empty),
      .count      (count)
   );

   always_comb begin
      cap_next = cap_state;
      cmd_seen = 1'b0;
      accept   = 1'b0;
      case (cap_state)
         CAP_IDLE: begin
            if (req_cmd_in != '0) begin
               cmd_seen = 1'b1;
               accept   = !busy[req_tag_in] && (count < CW'(CALC2_QDEPTH));
               cap_next = CAP_OP2;
            end
         end
         CAP_OP2: cap_next = CAP_IDLE;
         default: cap_next = CAP_IDLE;
      endcase
   end

   assign push       = (cap_state == CAP_OP2) && cap_keep && (!full || pop);
   assign push_entry = '{op: cap_op, tag: cap_tag, op1: cap_op1, op2: req_data_in};

   always_ff @(posedge c_clk or posedge reset) begin
      if (reset) begin
         cap_state <= CAP_IDLE;
         cap_op    <= op_none;
         cap_tag   <= '0;
         cap_op1   <= '0;
         cap_keep  <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         cap_state <= cap_next;
         if (cmd_seen) begin
            cap_op   <= operation_t'(req_cmd_in);
            cap_tag  <= req_tag_in;
            cap_op1  <= req_data_in;
            cap_keep <= accept;
         end
         if (cmd_seen && !accept) proto_err <= 1'b1;
      end
   end

   // The response is registered one cycle before it appears, so a 1-cycle op
   // fires straight from the head at pop and longer ops fire when cnt reaches 1.
   always_comb begin
      ex_next  = ex_state;
      cnt_next = cnt;
      pop      = 1'b0;
      fire     = 1'b0;
      fire_src = cur;
      case (ex_state)
         EX_IDLE: begin
            if (!empty) begin
               pop = 1'b1;
               if (lat_of(head.op) == 8'd1) begin
                  fire     = 1'b1;
                  fire_src = head;
               end else begin
                  cnt_next = lat_of(head.op) - 8'd1;
                  ex_next  = EX_BUSY;
               end
            end
         end
         EX_BUSY: begin
            cnt_next = cnt - 8'd1;
            if (cnt == 8'd1) begin
               fire    = 1'b1;
               ex_next = EX_IDLE;
            end
         end
         default: ex_next = EX_IDLE;
      endcase
   end

   assign res = calc2_alu(fire_src);

   always_comb begin
      busy_next = busy;
      if (fire) busy_next[fire_src.tag] = 1'b0;
      if (push) busy_next[cap_tag]      = 1'b1;
   end

   always_ff @(posedge c_clk or posedge reset) begin
      if (reset) begin
         ex_state <= EX_IDLE;
         cnt      <= '0;
         cur      <= '0;
         busy     <= '0;
         out_resp <= resp_none;
         out_data <= '0;
         out_tag  <= '0;
      end else begin
         ex_state <= ex_next;
         cnt      <= cnt_next;
         busy     <= busy_next;
         if (pop) cur <= head;
         out_resp <= fire ? res.resp : resp_none;
         if (fire) begin
            out_data <= res.data;
            out_tag  <= fire_src.tag;
         end
      end
   end

endmodule

// File: tb/tb_calc2_port_responder.sv
// Scoreboard bench for calc2_port_responder: the driver predicts acceptance, result
// and response cycle of each request; a negedge monitor checks what the DUT presents.
module tb_calc2_port_responder;

   localparam int unsigned ADD_LAT   = 2;
   localparam int unsigned SHIFT_LAT = 3;

   logic        clk      = 1'b0;
   logic        reset    = 1'b1;
   logic [3:0]  req_cmd  = '0;
   logic [1:0]  req_tag  = '0;
   logic [0:31] req_data = '0;
   logic [1:0]  out_resp;
   logic [0:31] out_data;
   logic [1:0]  out_tag;
   logic        proto_err;

   calc2_port_responder #(.ADD_LAT(ADD_LAT), .SHIFT_LAT(SHIFT_LAT)) dut (
      .c_clk       (clk),
      .reset       (reset),
      .req_cmd_in  (req_cmd),
      .req_tag_in  (req_tag),
      .req_data_in (req_data),
      .out_resp    (out_resp),
      .out_data    (out_data),
      .out_tag     (out_tag),
      .proto_err   (proto_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [1:0]  tag;
      logic [1:0]  resp;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   typedef struct {
      logic [1:0] tag;
      int         cmd_cyc;
      int         pop_cyc;
      int         out_cyc;
   } acc_t;

   exp_t exp_q[$];
   acc_t acc_q[$];
   int   last_out = 0;
   int   viol_cyc = -1;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic void ref_result(input logic [3:0] cmd, input logic [31:0] a,
                                      input logic [31:0] b, output logic [1:0] resp,
                                      output logic [31:0] data, output int lat);
      longint unsigned s;
      resp = 2'b01;
      data = '0;
      lat  = 1;
      case (cmd)
         4'd1: begin
            lat = ADD_LAT;
            s   = longint'(a) + longint'(b);
            if (s > 64'hFFFF_FFFF) resp = 2'b10;
            else                   data = 32'(s);
         end
         4'd2: begin
            lat = ADD_LAT;
            if (b > a) resp = 2'b10;
            else       data = a - b;
         end
         4'd5: begin lat = SHIFT_LAT; data = a << (b % 32); end
         4'd6: begin lat = SHIFT_LAT; data = a >> (b % 32); end
         default: resp = 2'b10;
      endcase
   endfunction

   // Called in the command cycle: decide acceptance from outstanding tags and
   // queue occupancy, then schedule the response after the previous one.
   task automatic model(input logic [3:0] cmd, input logic [1:0] tag,
                        input logic [31:0] a, input logic [31:0] b);
      int          n;
      bit          tag_busy;
      int          occ;
      logic [1:0]  r;
      logic [31:0] d;
      int          lat;
      int          pop;
      n        = cyc;
      tag_busy = 1'b0;
      occ      = 0;
      foreach (acc_q[i]) begin
         if (acc_q[i].tag == tag && acc_q[i].out_cyc > n) tag_busy = 1'b1;
         if (acc_q[i].cmd_cyc + 2 <= n && acc_q[i].pop_cyc >= n) occ++;
      end
      if (tag_busy || occ >= 4) begin
         if (viol_cyc < 0) viol_cyc = n;
      end else begin
         ref_result(cmd, a, b, r, d, lat);
         pop      = (n + 2 > last_out) ? n + 2 : last_out;
         last_out = pop + lat;
         acc_q.push_back('{tag, n, pop, last_out});
         exp_q.push_back('{tag, r, d, last_out});
      end
   endtask

   task automatic issue(input logic [3:0] cmd, input logic [1:0] tag,
                        input logic [31:0] a, input logic [31:0] b, input int gap);
      model(cmd, tag, a, b);
      req_cmd  = cmd;
      req_tag  = tag;
      req_data = a;
      @(posedge clk); #1;
      req_cmd  = 4'($urandom_range(1, 15));
      req_tag  = 2'($urandom_range(0, 3));
      req_data = b;
      @(posedge clk); #1;
      req_cmd  = '0;
      req_data = $urandom;
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   task automatic check_zero_outputs();
      chk("rst_resp", out_resp, 32'd0);
      chk("rst_data", out_data, 32'd0);
      chk("rst_tag", out_tag, 32'd0);
      chk("rst_proto_err", proto_err, 32'd0);
   endtask

   task automatic do_reset_mid();
      #2;
      exp_q.delete();
      acc_q.delete();
      last_out = 0;
      viol_cyc = -1;
      reset    = 1'b1;
      req_cmd  = '0;
      #1;
      check_zero_outputs();
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (out_resp != 2'b00) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_resp", out_resp, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("resp", out_resp, e.resp);
               chk("data", out_data, e.data);
               chk("tag", out_tag, e.tag);
               chk("resp_cycle", cyc, e.cyc);
            end
         end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            chk("resp_missing", out_resp, e.resp);
         end
         chk("proto_err", proto_err, (viol_cyc >= 0 && cyc > viol_cyc) ? 32'd1 : 32'd0);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  c;
      logic [31:0] a;
      logic [31:0] b;
      int          k;

      repeat (2) @(posedge clk);
      #1;
      check_zero_outputs();
      reset = 1'b0;
      @(posedge clk); #1;

      issue(4'd1, 2'd2, 32'h0000_0005, 32'h0000_0007, 4);
      issue(4'd1, 2'd0, 32'hFFFF_FFFF, 32'h0000_0001, 4);
      issue(4'd2, 2'd1, 32'd3, 32'd5, 4);
      issue(4'd2, 2'd3, 32'd5, 32'd3, 4);
      issue(4'd5, 2'd0, 32'h0000_0001, 32'h0000_0021, 5);
      issue(4'd6, 2'd1, 32'h8000_0000, 32'd31, 5);
      issue(4'd3, 2'd2, 32'h0000_1234, 32'h0000_0055, 3);

      issue(4'd1, 2'd0, 32'd100, 32'd1, 0);
      issue(4'd5, 2'd1, 32'h0000_00F0, 32'd4, 0);
      issue(4'd2, 2'd2, 32'd50, 32'd8, 0);
      issue(4'd1, 2'd3, 32'h7FFF_FFFF, 32'd1, 8);

      issue(4'd1, 2'd1, 32'd10, 32'd20, 0);
      issue(4'd2, 2'd1, 32'd30, 32'd5, 6);

      for (int i = 0; i < 200; i++) begin
         k = $urandom_range(0, 9);
         if (k < 3)      c = 4'd1;
         else if (k < 5) c = 4'd2;
         else if (k < 7) c = 4'd5;
         else if (k < 9) c = 4'd6;
         else begin
            do c = 4'($urandom_range(1, 15));
            while (c == 4'd1 || c == 4'd2 || c == 4'd5 || c == 4'd6);
         end
         a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
         b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
         issue(c, 2'($urandom_range(0, 3)), a, b, $urandom_range(0, 3));
      end

      repeat (20) begin @(posedge clk); #1; end
      issue(4'd5, 2'd0, 32'd1, 32'd1, 0);
      issue(4'd6, 2'd1, 32'hFFFF_0000, 32'd8, 0);
      issue(4'd5, 2'd2, 32'd3, 32'd2, 0);
      issue(4'd1, 2'd3, 32'd7, 32'd9, 0);
      do_reset_mid();

      repeat (12) begin @(posedge clk); #1; end
      issue(4'd1, 2'd2, 32'd100, 32'd23, 0);

      for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      chk("drained", exp_q.size(), 32'd0);
      repeat (3) begin @(posedge clk); #1; end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
